// File: rtl/dot_sequencer.sv
// dot_sequencer: steps a dot_driver array through a programmed pattern table.
// Each step has a dead gap with output_enable low, then a drive phase with it high.
//
// Ports:
//   clock, reset (async, active high)
//   cfg_we/cfg_addr/cfg_state/cfg_enable/cfg_dwell : step table write port
//   cfg_last_step/cfg_dead/cfg_loop : run settings, latched on start
//   start, stop : begin a run from step 0 / abort to IDLE
//   dot_state, dot_enable, output_enable : registered driver controls
//   busy, step_idx, done : status
module dot_sequencer #(
  parameter int NUM_DOTS = 8,
  parameter int STEPS    = 16,
  parameter int DWELL_W  = 16,
  parameter int DEAD_W   = 4,
  localparam int ADDR_W  = $clog2(STEPS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [NUM_DOTS-1:0] cfg_state,
  input  logic [NUM_DOTS-1:0] cfg_enable,
  input  logic [DWELL_W-1:0]  cfg_dwell,
  input  logic [ADDR_W-1:0]   cfg_last_step,
  input  logic [DEAD_W-1:0]   cfg_dead,
  input  logic                cfg_loop,
  input  logic                start,
  input  logic                stop,
  output logic [NUM_DOTS-1:0] dot_state,
  output logic [NUM_DOTS-1:0] dot_enable,
  output logic                output_enable,
  output logic                busy,
  output logic [ADDR_W-1:0]   step_idx,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    DRIVE
  } state_t;

  typedef struct packed {
    logic [NUM_DOTS-1:0] state;
    logic [NUM_DOTS-1:0] enable;
    logic [DWELL_W-1:0]  dwell;
  } entry_t;

  entry_t table_q [STEPS];

  state_t              state_q, state_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  logic                loop_q, loop_d;
  logic [ADDR_W-1:0]   idx_d;
  logic [NUM_DOTS-1:0] st_d, en_d;
  logic                oe_d, done_d;
  logic                fetch;
  logic [ADDR_W-1:0]   fetch_idx;

  // Table is deliberately not reset; it must be programmed before start.
  always_ff @(posedge clock) begin
    if (cfg_we) begin
      table_q[cfg_addr] <= '{cfg_state, cfg_enable, cfg_dwell};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dwell_q       <= '0;
      last_q        <= '0;
      dead_q        <= '0;
      loop_q        <= 1'b0;
      step_idx      <= '0;
      dot_state     <= '0;
      dot_enable    <= '0;
      output_enable <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dwell_q       <= dwell_d;
      last_q        <= last_d;
      dead_q        <= dead_d;
      loop_q        <= loop_d;
      step_idx      <= idx_d;
      dot_state     <= st_d;
      dot_enable    <= en_d;
      output_enable <= oe_d;
      done          <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dwell_d   = dwell_q;
    last_d    = last_q;
    dead_d    = dead_q;
    loop_d    = loop_q;
    idx_d     = step_idx;
    st_d      = dot_state;
    en_d      = dot_enable;
    oe_d      = output_enable;
    done_d    = 1'b0;
    fetch     = 1'b0;
    fetch_idx = step_idx;

    if (stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      st_d    = '0;
      en_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = DEAD;
            idx_d     = '0;
            last_d    = cfg_last_step;
            dead_d    = cfg_dead;
            loop_d    = cfg_loop;
            cnt_d     = DWELL_W'(cfg_dead);
            oe_d      = 1'b0;
            fetch     = 1'b1;
            fetch_idx = '0;
          end
        end
        DEAD: begin
          if (cnt_q == '0) begin
            state_d = DRIVE;
            oe_d    = 1'b1;
            cnt_d   = dwell_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            oe_d  = 1'b0;
            cnt_d = DWELL_W'(dead_q);
            if (step_idx != last_q) begin
              state_d   = DEAD;
              idx_d     = step_idx + 1'b1;
              fetch     = 1'b1;
              fetch_idx = step_idx + 1'b1;
            end else if (loop_q) begin
              state_d   = DEAD;
              idx_d     = '0;
              fetch     = 1'b1;
              fetch_idx = '0;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
              st_d    = '0;
              en_d    = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Table read happens before this edge's write lands, so a
    // same-edge write to the fetched address yields the old entry.
    if (fetch) begin
      st_d    = table_q[fetch_idx].state;
      en_d    = table_q[fetch_idx].enable;
      dwell_d = table_q[fetch_idx].dwell;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_dot_sequencer.sv
// tb_dot_sequencer: scoreboard bench for dot_sequencer.
// Expected per-cycle outputs are queued as stimulus is applied.
module tb_dot_sequencer;

  localparam int ND = 8;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int DT = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [ND-1:0] cfg_state = '0;
  logic [ND-1:0] cfg_enable = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [AW-1:0] cfg_last_step = '0;
  logic [DT-1:0] cfg_dead = '0;
  logic          cfg_loop = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [ND-1:0] dot_state;
  logic [ND-1:0] dot_enable;
  logic          output_enable;
  logic          busy;
  logic [AW-1:0] step_idx;
  logic          done;

  typedef struct packed {
    logic          oe;
    logic          busy;
    logic          done;
    logic [AW-1:0] idx;
    logic [ND-1:0] st;
    logic [ND-1:0] en;
  } obs_t;

  obs_t sb[$];
  obs_t got, exp;
  int   vecs = 0;
  int   errs = 0;

  dot_sequencer dut (
    .clock(clock), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_state(cfg_state), .cfg_enable(cfg_enable),
    .cfg_dwell(cfg_dwell), .cfg_last_step(cfg_last_step),
    .cfg_dead(cfg_dead), .cfg_loop(cfg_loop),
    .start(start), .stop(stop),
    .dot_state(dot_state), .dot_enable(dot_enable),
    .output_enable(output_enable), .busy(busy),
    .step_idx(step_idx), .done(done)
  );

  always #5 clock = ~clock;

  function automatic obs_t snap();
    return '{output_enable, busy, done, step_idx,
             dot_state, dot_enable};
  endfunction

  function automatic void push_step(logic [ND-1:0] s,
      logic [ND-1:0] e, logic [AW-1:0] i,
      int dead, int dwell);
    for (int k = 0; k <= dead; k++)
      sb.push_back('{1'b0, 1'b1, 1'b0, i, s, e});
    for (int k = 0; k <= dwell; k++)
      sb.push_back('{1'b1, 1'b1, 1'b0, i, s, e});
  endfunction

  function automatic void push_idle(logic [AW-1:0] i,
      logic d);
    sb.push_back('{1'b0, 1'b0, d, i, 8'h00, 8'h00});
  endfunction

  task automatic write_entry(logic [AW-1:0] a,
      logic [ND-1:0] s, logic [ND-1:0] e,
      logic [DW-1:0] dw);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_state = s;
    cfg_enable = e;
    cfg_dwell = dw;
    @(posedge clock);
    #1 cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    got = snap();
    vecs++;
    if (got !== '0) begin
      errs++;
      $display("FAIL reset_noclk got=%h exp=0", got);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    got = snap();
    vecs++;
    if (got !== '0) begin
      errs++;
      $display("FAIL reset_idle got=%h exp=0", got);
    end
  endtask

  task automatic test_single_run();
    write_entry(0, 8'hA5, 8'hFF, 16'd3);
    write_entry(1, 8'h5A, 8'h0F, 16'd1);
    cfg_last_step = 1;
    cfg_dead = 2;
    cfg_loop = 1'b0;
    start = 1'b1;
    push_step(8'hA5, 8'hFF, 0, 2, 3);
    push_step(8'h5A, 8'h0F, 1, 2, 1);
    push_idle(1, 1'b1);
    push_idle(1, 1'b0);
    push_idle(1, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      exp = sb.pop_front();
      got = snap();
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL single k=%0d got=%h exp=%h",
                 k, got, exp);
      end
    end
  endtask

  task automatic test_loop();
    cfg_loop = 1'b1;
    start = 1'b1;
    push_step(8'hA5, 8'hFF, 0, 2, 3);
    push_step(8'h5A, 8'h0F, 1, 2, 1);
    push_step(8'hA5, 8'hFF, 0, 2, 1);
    push_idle(0, 1'b0);
    push_idle(0, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      stop = 1'b0;
      exp = sb.pop_front();
      got = snap();
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL loop k=%0d got=%h exp=%h",
                 k, got, exp);
      end
      if (k == 16) stop = 1'b1;
    end
  endtask

  task automatic test_simultaneous();
    start = 1'b1;
    stop = 1'b1;
    push_idle(0, 1'b0);
    push_idle(0, 1'b0);
    cfg_loop = 1'b0;
    push_step(8'hA5, 8'hFF, 0, 2, 3);
    push_step(8'hC3, 8'h3C, 1, 2, 0);
    push_idle(1, 1'b1);
    push_idle(1, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      stop = 1'b0;
      cfg_we = 1'b0;
      exp = sb.pop_front();
      got = snap();
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL simult k=%0d got=%h exp=%h",
                 k, got, exp);
      end
      if (k == 1) start = 1'b1;
      if (k == 3) start = 1'b1;
      if (k == 6) begin
        cfg_we = 1'b1;
        cfg_addr = 1;
        cfg_state = 8'hC3;
        cfg_enable = 8'h3C;
        cfg_dwell = 16'd0;
      end
    end
  endtask

  task automatic test_shadow();
    cfg_last_step = 1;
    cfg_dead = 1;
    cfg_loop = 1'b0;
    start = 1'b1;
    push_step(8'hA5, 8'hFF, 0, 1, 3);
    push_step(8'hC3, 8'h3C, 1, 1, 0);
    push_idle(1, 1'b1);
    push_idle(1, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      cfg_we = 1'b0;
      exp = sb.pop_front();
      got = snap();
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL shadow k=%0d got=%h exp=%h",
                 k, got, exp);
      end
      if (k == 1) begin
        cfg_dead = 5;
        cfg_last_step = 0;
        cfg_loop = 1'b1;
      end
      if (k == 5) begin
        cfg_we = 1'b1;
        cfg_addr = 1;
        cfg_state = 8'h77;
        cfg_enable = 8'hEE;
        cfg_dwell = 16'd2;
      end
    end
    cfg_loop = 1'b0;
    start = 1'b1;
    push_step(8'hA5, 8'hFF, 0, 5, 3);
    push_idle(0, 1'b1);
    push_idle(0, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      exp = sb.pop_front();
      got = snap();
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL shadow2 k=%0d got=%h exp=%h",
                 k, got, exp);
      end
    end
  endtask

  task automatic test_min_timing();
    write_entry(0, 8'h81, 8'h18, 16'd0);
    cfg_last_step = 0;
    cfg_dead = 0;
    cfg_loop = 1'b0;
    start = 1'b1;
    push_step(8'h81, 8'h18, 0, 0, 0);
    push_idle(0, 1'b1);
    push_idle(0, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      exp = sb.pop_front();
      got = snap();
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL min k=%0d got=%h exp=%h",
                 k, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    write_entry(0, 8'hF0, 8'h0F, 16'd20);
    cfg_dead = 3;
    start = 1'b1;
    push_step(8'hF0, 8'h0F, 0, 3, 2);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      exp = sb.pop_front();
      got = snap();
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL arst_run k=%0d got=%h exp=%h",
                 k, got, exp);
      end
    end
    reset = 1'b1;
    #1;
    got = snap();
    vecs++;
    if (got !== '0) begin
      errs++;
      $display("FAIL arst_mid got=%h exp=0", got);
    end
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    got = snap();
    vecs++;
    if (got !== '0) begin
      errs++;
      $display("FAIL arst_after got=%h exp=0", got);
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_loop();
    test_simultaneous();
    test_shadow();
    test_min_timing();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
